// File: rtl/coordinate_reader.sv
// coordinate_reader: streams stored (x, y) pairs out of the coordinate RAM
// over a valid/ready handshake and mirrors them on six 7-segment digits.
module coordinate_reader #(
   parameter int COORD_W = 8,
   parameter int ADDR_W  = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W:0]      count,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [2*COORD_W-1:0] mem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [COORD_W-1:0]   out_x,
   output logic [COORD_W-1:0]   out_y,
   output logic                 out_last,
   output logic [6:0]           hex0,
   output logic [6:0]           hex1,
   output logic [6:0]           hex2,
   output logic [6:0]           hex3,
   output logic [6:0]           hex4,
   output logic [6:0]           hex5,
   output logic                 done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_PRESENT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [6:0] BLANK = 7'b1111111;

   logic [2:0]      state;
   logic [ADDR_W:0] idx;
   logic [ADDR_W:0] cnt_r;
   logic [ADDR_W:0] cnt_sat;
   logic            last_w;
   logic [7:0]      idx8;
   logic [7:0]      x8;
   logic [7:0]      y8;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign cnt_sat   = (count > CAP) ? CAP : count;
   assign last_w    = (idx == cnt_r - 1'b1);
   assign mem_rd_en = (state == S_READ);
   assign mem_addr  = idx[ADDR_W-1:0];
   assign out_valid = (state == S_PRESENT);
   assign out_last  = (state == S_PRESENT) && last_w;
   assign done      = (state == S_DONE);

   // Pass sequencing: read, wait for RAM data, present, repeat until last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         idx   <= '0;
         cnt_r <= '0;
         out_x <= '0;
         out_y <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  cnt_r <= cnt_sat;
                  idx   <= '0;
                  state <= (cnt_sat == '0) ? S_DONE : S_READ;
               end
            end
            S_READ: state <= S_WAIT;
            S_WAIT: begin
               out_x <= mem_rdata[2*COORD_W-1:COORD_W];
               out_y <= mem_rdata[COORD_W-1:0];
               state <= S_PRESENT;
            end
            S_PRESENT: begin
               if (out_ready) begin
                  if (last_w) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_READ;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Display decode straight from registered state and data.
   always_comb begin
      idx8 = 8'(idx);
      x8   = 8'(out_x);
      y8   = 8'(out_y);
      hex0 = BLANK;
      hex1 = BLANK;
      hex2 = BLANK;
      hex3 = BLANK;
      hex4 = BLANK;
      hex5 = BLANK;
      if (state == S_PRESENT) begin
         hex5 = seg7(idx8[7:4]);
         hex4 = seg7(idx8[3:0]);
         hex3 = seg7(x8[7:4]);
         hex2 = seg7(x8[3:0]);
         hex1 = seg7(y8[7:4]);
         hex0 = seg7(y8[3:0]);
      end else if (state == S_DONE) begin
         hex3 = 7'b0100001;
         hex2 = 7'b0100011;
         hex1 = 7'b0101011;
         hex0 = 7'b0000110;
      end
   end

endmodule
